// File: rtl/ram_arb_pkg.sv
// Shared state encoding, default widths and a clog2 helper for the RAM port arbiter.
package ram_arb_pkg;
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 32;

   function automatic int clog2(input int unsigned value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) r = i + 1;
      end
      return r;
   endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after i_last, wrapping modulo NUM_REQ.
// Zero latency; no backpressure (pure function of its inputs).
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [NUM_REQ-1:0] o_win_oh,
   output logic [IDX_W-1:0]   o_win_idx,
   output logic               o_any
);
   logic [IDX_W-1:0] w_cand;
   int               w_sum;

   // Scan from the farthest offset down so the nearest requester after i_last is written last.
   always_comb begin
      o_win_oh  = '0;
      o_win_idx = '0;
      w_cand    = '0;
      w_sum     = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_sum = int'(i_last) + k;
         if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
         w_cand = IDX_W'(w_sum);
         if (i_req[w_cand]) begin
            o_win_oh         = '0;
            o_win_oh[w_cand] = 1'b1;
            o_win_idx        = w_cand;
         end
      end
   end

   assign o_any = |i_req;
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin share of one RAM port, one transaction in flight; strobe the cycle after the request edge, ack one cycle after ram_ready.
// Clients hold requests until ack/err; optional watchdog enabled by macro RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_rd_en,
   input  logic [NUM_REQ-1:0]            req_wr_en,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [DATA_WIDTH-1:0]         req_rdata,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [NUM_REQ-1:0]            req_err,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic                          ram_read_en,
   output logic                          ram_write_en,
   output logic [ADDR_WIDTH-1:0]         ram_address,
   output logic [DATA_WIDTH-1:0]         ram_write_data,
   input  logic [DATA_WIDTH-1:0]         ram_read_data,
   input  logic                          ram_ready
);
   localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

   state_t                r_state, w_state_nxt;
   logic [IDX_W-1:0]      r_last, w_last_nxt;
   logic [IDX_W-1:0]      r_gidx, w_gidx_nxt;
   logic                  r_op_wr, w_op_wr_nxt;
   logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
   logic [NUM_REQ-1:0]    r_ack, w_ack_nxt;
   logic                  r_busy, w_busy_nxt;
   logic                  r_ram_rd, w_ram_rd_nxt;
   logic                  r_ram_wr, w_ram_wr_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
   logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;

   logic [NUM_REQ-1:0]    w_req;
   logic [NUM_REQ-1:0]    w_win_oh;
   logic [IDX_W-1:0]      w_win_idx;
   logic                  w_any;
   logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

`ifdef RAM_ARB_TIMEOUT_EN
   localparam int TMO_W = clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]      r_tmo_cnt, w_tmo_cnt_nxt;
   logic [NUM_REQ-1:0]    r_err, w_err_nxt;
`else
   logic                  w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

   assign w_req = req_rd_en | req_wr_en;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = req_addr[(gi+1)*ADDR_WIDTH-1 -: ADDR_WIDTH];
      assign w_wdata_arr[gi] = req_wdata[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH];
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .i_req     (w_req),
      .i_last    (r_last),
      .o_win_oh  (w_win_oh),
      .o_win_idx (w_win_idx),
      .o_any     (w_any)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_last_nxt   = r_last;
      w_gidx_nxt   = r_gidx;
      w_op_wr_nxt  = r_op_wr;
      w_grant_nxt  = r_grant;
      w_busy_nxt   = r_busy;
      w_ram_rd_nxt = r_ram_rd;
      w_ram_wr_nxt = r_ram_wr;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_rdata_nxt  = r_rdata;
      w_ack_nxt    = '0;
`ifdef RAM_ARB_TIMEOUT_EN
      w_tmo_cnt_nxt = r_tmo_cnt;
      w_err_nxt     = '0;
`endif
      case (r_state)
         IDLE: begin
            if (w_any) begin
               // Write wins when a client raises rd and wr together.
               w_op_wr_nxt  = req_wr_en[w_win_idx];
               w_ram_wr_nxt = req_wr_en[w_win_idx];
               w_ram_rd_nxt = ~req_wr_en[w_win_idx];
               w_addr_nxt   = w_addr_arr[w_win_idx];
               w_wdata_nxt  = w_wdata_arr[w_win_idx];
               w_gidx_nxt   = w_win_idx;
               w_grant_nxt  = w_win_oh;
               w_busy_nxt   = 1'b1;
               w_state_nxt  = ISSUE;
`ifdef RAM_ARB_TIMEOUT_EN
               w_tmo_cnt_nxt = '0;
`endif
            end
         end
         ISSUE: begin
            if (ram_ready) begin
               w_ram_rd_nxt = 1'b0;
               w_ram_wr_nxt = 1'b0;
               if (!r_op_wr) w_rdata_nxt = ram_read_data;
               w_ack_nxt    = r_grant;
               w_state_nxt  = RESP;
            end
`ifdef RAM_ARB_TIMEOUT_EN
            else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               w_ram_rd_nxt = 1'b0;
               w_ram_wr_nxt = 1'b0;
               w_rdata_nxt  = '0;
               w_err_nxt    = r_grant;
               w_state_nxt  = RESP;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
            end
`endif
         end
         RESP: begin
            w_last_nxt  = r_gidx;
            w_grant_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_last   <= IDX_W'(NUM_REQ - 1);
         r_gidx   <= '0;
         r_op_wr  <= 1'b0;
         r_grant  <= '0;
         r_ack    <= '0;
         r_busy   <= 1'b0;
         r_ram_rd <= 1'b0;
         r_ram_wr <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
         r_tmo_cnt <= '0;
         r_err     <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_last   <= w_last_nxt;
         r_gidx   <= w_gidx_nxt;
         r_op_wr  <= w_op_wr_nxt;
         r_grant  <= w_grant_nxt;
         r_ack    <= w_ack_nxt;
         r_busy   <= w_busy_nxt;
         r_ram_rd <= w_ram_rd_nxt;
         r_ram_wr <= w_ram_wr_nxt;
         r_addr   <= w_addr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_rdata  <= w_rdata_nxt;
`ifdef RAM_ARB_TIMEOUT_EN
         r_tmo_cnt <= w_tmo_cnt_nxt;
         r_err     <= w_err_nxt;
`endif
      end
   end

   assign req_rdata      = r_rdata;
   assign req_ack        = r_ack;
   assign grant          = r_grant;
   assign busy           = r_busy;
   assign ram_read_en    = r_ram_rd;
   assign ram_write_en   = r_ram_wr;
   assign ram_address    = r_addr;
   assign ram_write_data = r_wdata;
`ifdef RAM_ARB_TIMEOUT_EN
   assign req_err = r_err;
`else
   assign req_err = '0;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomized bench for ram_port_arbiter against a round-robin reference model.
module tb_ram_port_arbiter;
   localparam int N  = 2;
   localparam int AW = 16;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_rd_en, req_wr_en;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   req_rdata;
   logic [N-1:0]    req_ack, req_err, grant;
   logic            busy, ram_read_en, ram_write_en, ram_ready;
   logic [AW-1:0]   ram_address;
   logic [DW-1:0]   ram_write_data, ram_read_data;

   int n_cmp = 0;
   int n_bad = 0;

   ram_port_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rdata(req_rdata), .req_ack(req_ack), .req_err(req_err),
      .grant(grant), .busy(busy),
      .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
      .ram_address(ram_address), .ram_write_data(ram_write_data),
      .ram_read_data(ram_read_data), .ram_ready(ram_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference rule: first requester at offsets last+1, last+2, ... modulo N.
   function automatic int rr_pick(input logic [N-1:0] pend, input int last);
      for (int k = 1; k <= N; k++) begin
         if (pend[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   task automatic set_client(input int i, input bit rd, input bit wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_rd_en[i]         = rd;
      req_wr_en[i]         = wr;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   int            m_last;
   logic [DW-1:0] m_rdata;
   logic [N-1:0]  pend;
   logic [N-1:0]  pwr;
   logic [AW-1:0] paddr [N];
   logic [DW-1:0] pdat  [N];
   int            w, d;
   bit            ok;
   logic [DW-1:0] rnd;

   initial begin
      rst = 1'b1;
      req_rd_en = '0; req_wr_en = '0; req_addr = '0; req_wdata = '0;
      ram_ready = 1'b0; ram_read_data = '0;
      m_last = N - 1; m_rdata = '0; pend = '0; pwr = '0;
      repeat (3) step();
      chk("rst_ack", req_ack, 0);
      chk("rst_err", req_err, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", ram_read_en, 0);
      chk("rst_wr_en", ram_write_en, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_rdata", req_rdata, 0);
      rst = 1'b0;

      // Single read, RAM ready one cycle after the strobe.
      set_client(0, 1, 0, 16'h0040, '0);
      step();
      chk("rd_strobe", ram_read_en, 1);
      chk("rd_wr_low", ram_write_en, 0);
      chk("rd_addr", ram_address, 16'h0040);
      chk("rd_grant", grant, 2'b01);
      chk("rd_busy", busy, 1);
      step();
      chk("rd_strobe_hold", ram_read_en, 1);
      chk("rd_no_early_ack", req_ack, 0);
      ram_ready = 1'b1; ram_read_data = 32'hDEADBEEF;
      step();
      ram_ready = 1'b0;
      m_rdata = 32'hDEADBEEF; m_last = 0;
      chk("rd_strobe_drop", ram_read_en, 0);
      chk("rd_ack", req_ack, 2'b01);
      chk("rd_rdata", req_rdata, m_rdata);
      chk("rd_err", req_err, 0);
      set_client(0, 0, 0, '0, '0);
      step();
      chk("rd_ack_one_cycle", req_ack, 0);
      chk("rd_grant_clear", grant, 0);
      chk("rd_busy_clear", busy, 0);

      // Contention from reset with RAM always ready.
      rst = 1'b1; step(); rst = 1'b0; m_last = N - 1;
      set_client(0, 1, 0, 16'h0100, '0);
      set_client(1, 1, 0, 16'h0200, '0);
      ram_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         w = rr_pick(2'b11, m_last);
         ram_read_data = 32'hC0DE0000 + t;
         step();
         chk("cont_grant", grant, oh(w));
         chk("cont_order", grant, (t % 2 == 0) ? 2'b01 : 2'b10);
         chk("cont_strobe", ram_read_en, 1);
         chk("cont_addr", ram_address, (w == 0) ? 16'h0100 : 16'h0200);
         chk("cont_no_ack", req_ack, 0);
         step();
         m_rdata = 32'hC0DE0000 + t; m_last = w;
         chk("cont_ack", req_ack, oh(w));
         chk("cont_rdata", req_rdata, m_rdata);
         chk("cont_strobe_drop", ram_read_en, 0);
         step();
         chk("cont_gap_grant", grant, 0);
         chk("cont_gap_ack", req_ack, 0);
      end
      ram_ready = 1'b0;
      set_client(0, 0, 0, '0, '0);
      set_client(1, 0, 0, '0, '0);

      // Write, then rd+wr together which must issue as a write.
      set_client(1, 0, 1, 16'h1234, 32'hA5A5A5A5);
      step();
      chk("wr_strobe", ram_write_en, 1);
      chk("wr_rd_low", ram_read_en, 0);
      chk("wr_addr", ram_address, 16'h1234);
      chk("wr_data", ram_write_data, 32'hA5A5A5A5);
      chk("wr_grant", grant, 2'b10);
      ram_ready = 1'b1; ram_read_data = 32'h0BADF00D;
      step();
      ram_ready = 1'b0; m_last = 1;
      chk("wr_ack", req_ack, 2'b10);
      chk("wr_rdata_kept", req_rdata, m_rdata);
      set_client(1, 1, 1, 16'h0008, 32'h5A5A0008);
      step();
      chk("wr_gap_grant", grant, 0);
      step();
      chk("rdwr_is_write", ram_write_en, 1);
      chk("rdwr_no_read", ram_read_en, 0);
      chk("rdwr_addr", ram_address, 16'h0008);
      chk("rdwr_data", ram_write_data, 32'h5A5A0008);
      ram_ready = 1'b1;
      step();
      ram_ready = 1'b0;
      chk("rdwr_ack", req_ack, 2'b10);
      chk("rdwr_rdata_kept", req_rdata, m_rdata);
      set_client(1, 0, 0, '0, '0);
      step();

      // Client drops its request mid-transaction; then stray ram_ready in IDLE.
      set_client(0, 1, 0, 16'h0777, '0);
      step();
      chk("drop_grant", grant, 2'b01);
      set_client(0, 0, 0, '0, '0);
      step();
      chk("drop_strobe_hold", ram_read_en, 1);
      ram_ready = 1'b1; ram_read_data = 32'h13572468;
      step();
      ram_ready = 1'b0; m_rdata = 32'h13572468; m_last = 0;
      chk("drop_ack", req_ack, 2'b01);
      chk("drop_rdata", req_rdata, m_rdata);
      step();
      ram_ready = 1'b1; ram_read_data = 32'hFFFF0000;
      step();
      ram_ready = 1'b0;
      chk("stray_busy", busy, 0);
      chk("stray_grant", grant, 0);
      chk("stray_ack", req_ack, 0);
      chk("stray_strobe", ram_read_en | ram_write_en, 0);
      chk("stray_rdata", req_rdata, m_rdata);

      // Reset during ISSUE with ram_ready withheld.
      set_client(0, 1, 0, 16'h0ABC, '0);
      step();
      chk("mrst_strobe_pre", ram_read_en, 1);
      rst = 1'b1;
      #1;
      chk("mrst_strobe_async", ram_read_en, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_grant", grant, 0);
      step();
      chk("mrst_no_ack", req_ack, 0);
      rst = 1'b0; m_last = N - 1; m_rdata = '0;
      set_client(1, 1, 0, 16'h0DEF, '0);
      step();
      w = rr_pick(2'b11, m_last);
      chk("mrst_first_grant", grant, oh(w));
      chk("mrst_client0_first", grant, 2'b01);
      ram_ready = 1'b1; ram_read_data = 32'h22223333;
      step();
      ram_ready = 1'b0; m_rdata = 32'h22223333; m_last = w;
      chk("mrst_ack", req_ack, oh(w));
      set_client(0, 0, 0, '0, '0);
      set_client(1, 0, 0, '0, '0);
      step();

      // Randomized traffic against the round-robin reference model.
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1; pwr[i] = $urandom_range(0, 1) == 1;
               paddr[i] = AW'($urandom); pdat[i] = $urandom;
               set_client(i, pwr[i] ? ($urandom_range(0, 1) == 1) : 1'b1, pwr[i], paddr[i], pdat[i]);
            end
         end
         if (pend == '0) begin
            w = $urandom_range(0, N - 1);
            pend[w] = 1'b1; pwr[w] = 1'b0; paddr[w] = AW'($urandom); pdat[w] = $urandom;
            set_client(w, 1, 0, paddr[w], pdat[w]);
         end
         ok = 1'b0;
         for (int c = 0; c < 20; c++) begin
            step();
            if (ram_read_en | ram_write_en) begin
               ok = 1'b1;
               break;
            end
         end
         chk("rnd_strobe_seen", ok, 1);
         if (!ok) break;
         w = rr_pick(pend, m_last);
         chk("rnd_grant", grant, oh(w));
         chk("rnd_wr_en", ram_write_en, pwr[w]);
         chk("rnd_rd_en", ram_read_en, !pwr[w]);
         chk("rnd_addr", ram_address, paddr[w]);
         if (pwr[w]) chk("rnd_wdata", ram_write_data, pdat[w]);
         d = $urandom_range(0, 3);
         for (int c = 0; c < d; c++) begin
            step();
            chk("rnd_strobe_hold", ram_read_en | ram_write_en, 1);
         end
         rnd = $urandom;
         ram_ready = 1'b1; ram_read_data = rnd;
         step();
         ram_ready = 1'b0;
         if (!pwr[w]) m_rdata = rnd;
         chk("rnd_ack", req_ack, oh(w));
         chk("rnd_err", req_err, 0);
         chk("rnd_rdata", req_rdata, m_rdata);
         chk("rnd_strobe_drop", ram_read_en | ram_write_en, 0);
         pend[w] = 1'b0; m_last = w;
         set_client(w, 0, 0, '0, '0);
      end
      for (int i = 0; i < N; i++) set_client(i, 0, 0, '0, '0);
      pend = '0;
      step();
      step();

`ifdef RAM_ARB_TIMEOUT_EN
      // Watchdog expiry, then ram_ready landing on the expiry cycle.
      set_client(0, 1, 0, 16'h0100, '0);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("tmo_strobe", ram_read_en, 1);
      end
      step();
      m_rdata = '0; m_last = 0;
      chk("tmo_strobe_drop", ram_read_en, 0);
      chk("tmo_err", req_err, 2'b01);
      chk("tmo_no_ack", req_ack, 0);
      chk("tmo_rdata", req_rdata, m_rdata);
      set_client(0, 0, 0, '0, '0);
      step();
      chk("tmo_err_one_cycle", req_err, 0);
      chk("tmo_busy", busy, 0);
      set_client(0, 1, 0, 16'h0104, '0);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("tmo2_strobe", ram_read_en, 1);
      end
      ram_ready = 1'b1; ram_read_data = 32'hFEEDF00D;
      step();
      ram_ready = 1'b0; m_rdata = 32'hFEEDF00D;
      chk("tmo2_ack", req_ack, 2'b01);
      chk("tmo2_no_err", req_err, 0);
      chk("tmo2_rdata", req_rdata, m_rdata);
      set_client(0, 0, 0, '0, '0);
      step();
`else
      chk("noerr_idle", req_err, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
